// File: rtl/poly_bram_pkg.sv
// Shared types and constants for the evk polynomial-coefficient BRAM reader.
// Four dual-port banks give eight coefficient lanes per beat.
package poly_bram_pkg;

    localparam int NBANK  = 4;
    localparam int LANES  = 2 * NBANK;
    localparam int COEF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

    typedef struct packed {
        logic [LANES*COEF_W-1:0] data;
        logic                    last;
    } beat_t;

endpackage

// File: rtl/poly_beat_fifo.sv
// Synchronous skid FIFO for output beats; head is read straight from storage.
// Flush empties it in one cycle without touching the stored words.
module poly_beat_fifo #(
    parameter int WIDTH = 257,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/poly_coeff_bram_reader.sv
// Read-side initiator for the 4-bank dual-port evk coefficient BRAM.
// Issues one beat per cycle under a FIFO credit limit and streams 8-lane beats.
module poly_coeff_bram_reader
    import poly_bram_pkg::*;
#(
    parameter int DLEN       = 32,
    parameter int HLEN       = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [HLEN-2:0]             start_beat,
    input  logic [HLEN-1:0]             num_beats,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DLEN-1:0]       out_data,
    output logic                        out_last,
    output logic [NBANK-1:0]            bram_en,
    output logic [NBANK-1:0]            bram_we,
    output logic [NBANK-1:0][HLEN-1:0]  bram_addr_a,
    output logic [NBANK-1:0][HLEN-1:0]  bram_addr_b,
    output logic [NBANK-1:0][DLEN-1:0]  bram_di_a,
    output logic [NBANK-1:0][DLEN-1:0]  bram_di_b,
    input  logic [NBANK-1:0][DLEN-1:0]  bram_do_a,
    input  logic [NBANK-1:0][DLEN-1:0]  bram_do_b,
    output logic                        bram_reset
);

    localparam int BW = HLEN - 1;
    localparam int DW = LANES * DLEN;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    reader_state_t   state;
    logic [BW-1:0]   beat;
    logic [HLEN-1:0] remaining;
    logic            inflight;
    logic            inflight_last;
    logic            issue;
    logic            pop;
    logic            flush;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occupancy;
    logic [DW:0]     push_data;
    logic [DW:0]     head;

    // Credit covers both queued beats and the one still in the BRAM pipe.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign issue     = (state == RUN) && (occupancy < (CW+1)'(FIFO_DEPTH));

    assign busy        = (state != IDLE);
    assign flush       = abort && (state != IDLE);
    assign bram_en     = {NBANK{issue}};
    assign bram_we     = '0;
    assign bram_addr_a = {NBANK{beat, 1'b0}};
    assign bram_addr_b = {NBANK{beat, 1'b1}};
    assign bram_di_a   = '0;
    assign bram_di_b   = '0;
    assign bram_reset  = 1'b0;

    assign out_valid = (fifo_count != '0);
    assign out_data  = head[DW:1];
    assign out_last  = out_valid & head[0];
    assign pop       = out_valid & out_ready;

    always_comb begin
        push_data = '0;
        for (int b = 0; b < NBANK; b++) begin
            push_data[1 + (2*b)*DLEN   +: DLEN] = bram_do_a[b];
            push_data[1 + (2*b+1)*DLEN +: DLEN] = bram_do_b[b];
        end
        push_data[0] = inflight_last;
    end

    poly_beat_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (remaining == HLEN'(1));
            if (flush) begin
                state         <= IDLE;
                inflight      <= 1'b0;
                inflight_last <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_beats == '0) begin
                                done <= 1'b1;
                            end else begin
                                state     <= RUN;
                                beat      <= start_beat;
                                remaining <= num_beats;
                            end
                        end
                    end
                    RUN: begin
                        if (issue) begin
                            beat      <= beat + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == HLEN'(1)) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop && out_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_poly_coeff_bram_reader.sv
// Directed bench for poly_coeff_bram_reader with a 1-cycle BRAM model.
// Bank k holds k<<16 | addr on both ports.
module tb_poly_coeff_bram_reader;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [5:0]        start_beat;
    logic [6:0]        num_beats;
    logic              abort;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [255:0]      out_data;
    logic              out_last;
    logic [3:0]        bram_en;
    logic [3:0]        bram_we;
    logic [3:0][6:0]   bram_addr_a;
    logic [3:0][6:0]   bram_addr_b;
    logic [3:0][31:0]  bram_di_a;
    logic [3:0][31:0]  bram_di_b;
    logic [3:0][31:0]  bram_do_a;
    logic [3:0][31:0]  bram_do_b;
    logic              bram_reset;

    int checks = 0;
    int errors = 0;
    logic [15:0] pat = 16'b1001_0110_1100_1001;

    always #5 clk = ~clk;

    poly_coeff_bram_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_beat  (start_beat),
        .num_beats   (num_beats),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr_a (bram_addr_a),
        .bram_addr_b (bram_addr_b),
        .bram_di_a   (bram_di_a),
        .bram_di_b   (bram_di_b),
        .bram_do_a   (bram_do_a),
        .bram_do_b   (bram_do_b),
        .bram_reset  (bram_reset)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bram_en[k]) begin
                bram_do_a[k] <= (32'(k) << 16) | 32'(bram_addr_a[k]);
                bram_do_b[k] <= (32'(k) << 16) | 32'(bram_addr_b[k]);
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_beat(input int b);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++) begin
                v[(2*k+p)*32 +: 32] = 32'((k << 16) | (2*b + p));
            end
        end
        return v;
    endfunction

    // Called on a negedge with the DUT idle; returns on a negedge.
    task automatic stream(input int sb, input int nb, input bit bp);
        int got, cyc, issued, first, viol;
        bit held_v;
        logic [255:0] held;
        got = 0; cyc = 0; issued = 0; first = -1; viol = 0;
        held_v = 0; held = '0;
        start = 1; start_beat = 6'(sb); num_beats = 7'(nb); out_ready = 1;
        @(negedge clk);
        start = 0;
        cyc = 1;
        check("en_cycle1", 256'(bram_en), 256'(4'hf));
        while (got < nb && cyc < 3000) begin
            if (bp) out_ready = pat[cyc % 16];
            if (bram_en != 4'h0) begin
                if (bram_en != 4'hf || issued - got >= 4) viol++;
                issued++;
            end
            if (held_v) begin
                check("stall_valid", 256'(out_valid), 256'(1));
                check("stall_data", out_data, held);
            end
            held_v = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                check("beat_data", out_data, exp_beat((sb + got) % 64));
                check("beat_last", 256'(out_last), 256'(got == nb - 1));
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        check("beat_count", 256'(got), 256'(nb));
        check("issue_count", 256'(issued), 256'(nb));
        check("credit", 256'(viol), 256'(0));
        if (!bp) begin
            check("first_latency", 256'(first), 256'(3));
            check("throughput", 256'(cyc), 256'(nb + 3));
        end
        check("done_pulse", 256'(done), 256'(1));
        check("busy_after", 256'(busy), 256'(0));
        check("valid_after", 256'(out_valid), 256'(0));
        @(negedge clk);
        check("done_cleared", 256'(done), 256'(0));
    endtask

    initial begin
        reset = 1; start = 0; start_beat = '0; num_beats = '0;
        abort = 0; out_ready = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_outputs",
              256'({busy, done, out_valid, out_last, bram_en}), 256'(0));
        check("rst_data", out_data, 256'(0));
        check("tied_zero", 256'({bram_we, bram_reset, bram_di_a, bram_di_b}),
              256'(0));
        @(negedge clk);

        stream(0, 64, 0);
        stream(62, 4, 0);
        stream(5, 16, 1);

        // zero length
        start = 1; start_beat = 6'd9; num_beats = 7'd0;
        @(negedge clk);
        start = 0;
        check("zero_done", 256'(done), 256'(1));
        check("zero_busy", 256'({busy, out_valid, bram_en}), 256'(0));
        @(negedge clk);
        check("zero_done_clr", 256'({done, out_valid}), 256'(0));

        // abort in cycle 5, then restart
        start = 1; start_beat = 6'd10; num_beats = 7'd32; out_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_state", 256'({out_valid, busy, done}), 256'(0));
        @(negedge clk);
        check("abort_no_done", 256'({out_valid, busy, done}), 256'(0));
        stream(20, 5, 0);

        // reset mid-DRAIN with an ignored start
        out_ready = 0;
        start = 1; start_beat = 6'd40; num_beats = 7'd3;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        start = 1; start_beat = 6'd0; num_beats = 7'd5;
        @(negedge clk);
        start = 0;
        check("drain_busy", 256'(busy), 256'(1));
        check("drain_head", out_data, exp_beat(40));
        check("drain_vl", 256'({out_valid, out_last, bram_en}),
              256'({1'b1, 1'b0, 4'h0}));
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("midrst_outputs",
              256'({busy, done, out_valid, out_last, bram_en}), 256'(0));
        check("midrst_data", out_data, 256'(0));
        out_ready = 1;
        @(negedge clk);
        check("midrst_idle", 256'({busy, done, out_valid, bram_en}), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_coeff_bram_reader.md
Name: poly_coeff_bram_reader

Overview:
- Read-side initiator for the 4-bank dual-port polynomial-coefficient BRAM (evk even/odd store).
- Given a start beat and a beat count, issues reads on all 8 bank ports and collects the 1-cycle-latency read data.
- Streams coefficients out as 8-coefficient beats over a valid/ready handshake.
- Feeds the automorphism/key-switch datapath. Never writes the BRAM.

Parameters:
- DLEN, 32, coefficient width in bits.
- HLEN, 7, BRAM address width; bank depth = 2^HLEN; beats per full polynomial = 2^(HLEN-1).
- FIFO_DEPTH, 4, output skid FIFO depth; minimum 2; at least 3 required for full throughput.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a transfer; accepted only in IDLE.
- start_beat  in  HLEN-1  first beat index.
- num_beats  in  HLEN  beat count, 0 to 2^(HLEN-1).
- abort  in  1  cancel the current transfer.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last beat handshake.
- out_valid  in/out: out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  8*DLEN  lane l occupies bits [l*DLEN +: DLEN].
- out_last  out  1  marks the final beat of the transfer.
- bram_en  out  4x1  per-bank enable.
- bram_we  out  4x1  per-bank write enable; tied 0.
- bram_addr_a  out  4xHLEN  port A address per bank.
- bram_addr_b  out  4xHLEN  port B address per bank.
- bram_di_a  out  4xDLEN  tied 0.
- bram_di_b  out  4xDLEN  tied 0.
- bram_do_a  in  4xDLEN  port A read data.
- bram_do_b  in  4xDLEN  port B read data.
- bram_reset  out  1  tied 0.

Behaviour:
- Lane mapping:
  - lane l = 2*bank + port (port A = 0, port B = 1).
  - For beat b: addr_a = 2b, addr_b = 2b+1, identical across all banks.
  - All four bram_en bits are driven together.
- Reset: state IDLE; busy, done, out_valid, out_last and bram_en all 0; out_data 0; FIFO empty; in-flight flag cleared. Reset mid-transfer discards everything, with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN on start. If num_beats = 0, go straight to IDLE and pulse done in the next cycle; no beats are emitted.
  - RUN: a read issues (bram_en = 1) when fifo_count + inflight < FIFO_DEPTH. The beat counter increments modulo 2^(HLEN-1), so start_beat + num_beats wraps. Move to DRAIN after the last issue.
  - DRAIN: when the last beat handshakes (out_valid & out_ready & out_last), return to IDLE and pulse done in the following cycle.
- Read pipeline:
  - A registered inflight flag marks cycles where bram_do holds fresh data; that data is pushed into the FIFO in that cycle.
  - Latency: start in cycle 0, bram_en in cycle 1, bram_do valid in cycle 2, out_valid in cycle 3.
  - With out_ready held high and FIFO_DEPTH >= 3, throughput is 1 beat per cycle.
- Issue is never gated on out_ready within the same cycle, so there is no combinational ready-to-en path.
- Handshake:
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - The FIFO never overflows; the credit rule guarantees this.
- out_last travels with its beat through the FIFO.
- abort (any non-IDLE state): next cycle IDLE, FIFO flushed, inflight cleared, out_valid=0, no done pulse. abort has priority over start. In IDLE, abort is ignored.
- start while busy is ignored.
- bram_en = 0 whenever no read issues; the BRAM holds do, but do is consumed only when inflight=1.

Decomposition:
- Package poly_bram_pkg holds:
  - NBANK = 4, LANES = 8.
  - typedef enum reader_state_t {IDLE, RUN, DRAIN}.
  - typedef beat_t: logic [LANES*DLEN-1:0] plus the last bit.
- One sub-module: poly_beat_fifo, a synchronous FIFO of width LANES*DLEN+1 and depth FIFO_DEPTH, with count output and registered output.

Test Plan:
- Full polynomial (HLEN=7): start_beat=0, num_beats=64, BRAM preloaded with value = bank<<16 | addr, out_ready=1.
  - First out_valid in cycle 3; 64 consecutive beats.
  - Beat b lane 2k+p = k<<16 | (2b+p).
  - out_last on beat 63; done 1 cycle after.
- Wrap-around: start_beat=62, num_beats=4 -> beats 62, 63, 0, 1 in order; addresses wrap to 0.
- Backpressure: out_ready toggled 1-0-0-1 pseudo-randomly, num_beats=16.
  - All 16 beats in order, none dropped or duplicated.
  - bram_en never asserts when fifo_count + inflight = FIFO_DEPTH.
  - out_data stable while stalled.
- Zero length: num_beats=0 -> no out_valid; done pulses in cycle 1; busy falls.
- Abort and restart: abort in cycle 5 of a 32-beat transfer -> out_valid=0 and busy=0 the next cycle, no done. A new start then streams cleanly from its own start_beat.
- Reset mid-DRAIN: all outputs return to reset values the next cycle; a start issued while busy is ignored.
